// File: rtl/food_spawner.sv
// Food placement engine: picks a free playfield cell using an external LFSR, falling back to a row-major scan.
// Latency: 6 cycles best case (spawn_req edge to food_valid); each extra random candidate costs 3-5 cycles, each scanned cell 3.
// Backpressure: none; spawn_req while busy is dropped, occupancy answers are expected exactly one cycle after occ_req.
module food_spawner #(
    parameter int GRID_W    = 20,
    parameter int GRID_H    = 15,
    parameter int MAX_TRIES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spawn_req,
    output logic       lfsr_step,
    input  logic [8:0] lfsr_state,
    output logic       occ_req,
    output logic [4:0] occ_x,
    output logic [3:0] occ_y,
    input  logic       occ_hit,
    output logic [4:0] food_x,
    output logic [3:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       spawn_fail
);

    localparam logic [5:0] W_LIM   = 6'(GRID_W);
    localparam logic [4:0] H_LIM   = 5'(GRID_H);
    localparam logic [4:0] X_LAST  = 5'(GRID_W - 1);
    localparam logic [3:0] Y_LAST  = 4'(GRID_H - 1);
    localparam logic [6:0] TRY_LIM = 7'(MAX_TRIES);

    typedef enum logic [2:0] {
        IDLE, STEP, SETTLE, CAND, PROBE, WAIT, SCAN, DONE
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] tries_q, tries_d;
    logic [4:0] scan_x_q, scan_x_d;
    logic [3:0] scan_y_q, scan_y_d;
    logic [4:0] cand_x_q, cand_x_d;
    logic [3:0] cand_y_q, cand_y_d;
    logic [4:0] food_x_q, food_x_d;
    logic [3:0] food_y_q, food_y_d;
    logic       food_valid_q, food_valid_d;
    logic       spawn_fail_q, spawn_fail_d;
    logic       lfsr_step_q, occ_req_q, busy_q;

    logic       reject;
    logic       scanning;
    logic       scan_last;
    logic [6:0] tries_inc;

    // The fallback scan is entered exactly when the random budget is spent, so the tries count doubles as the mode flag.
    assign scanning  = (tries_q == TRY_LIM);
    assign scan_last = (scan_x_q == X_LAST) && (scan_y_q == Y_LAST);
    assign tries_inc = tries_q + 7'd1;

    // Next-state and datapath decisions for the placement sequence.
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        scan_x_d     = scan_x_q;
        scan_y_d     = scan_y_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        spawn_fail_d = spawn_fail_q;
        reject       = 1'b0;

        case (state_q)
            IDLE: begin
                if (spawn_req) begin
                    state_d      = STEP;
                    food_valid_d = 1'b0;
                    spawn_fail_d = 1'b0;
                    tries_d      = '0;
                end
            end
            STEP:   state_d = SETTLE;
            SETTLE: state_d = CAND;
            CAND: begin
                cand_x_d = lfsr_state[4:0];
                cand_y_d = lfsr_state[8:5];
                if (({1'b0, lfsr_state[4:0]} < W_LIM) && ({1'b0, lfsr_state[8:5]} < H_LIM)) begin
                    state_d = PROBE;
                end else begin
                    reject = 1'b1;
                end
            end
            PROBE: state_d = WAIT;
            WAIT: begin
                if (!occ_hit) begin
                    state_d = DONE;
                end else if (scanning) begin
                    if (scan_last) begin
                        spawn_fail_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        if (scan_x_q == X_LAST) begin
                            scan_x_d = '0;
                            scan_y_d = scan_y_q + 4'd1;
                        end else begin
                            scan_x_d = scan_x_q + 5'd1;
                        end
                        state_d = SCAN;
                    end
                end else begin
                    reject = 1'b1;
                end
            end
            SCAN: begin
                cand_x_d = scan_x_q;
                cand_y_d = scan_y_q;
                state_d  = PROBE;
            end
            DONE: begin
                food_x_d     = cand_x_q;
                food_y_d     = cand_y_q;
                food_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (reject) begin
            tries_d = tries_inc;
            if (tries_inc == TRY_LIM) begin
                scan_x_d = '0;
                scan_y_d = '0;
                state_d  = SCAN;
            end else begin
                state_d = STEP;
            end
        end
    end

    // State and datapath registers; strobes are decoded from the next state so they leave flops cleanly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tries_q      <= '0;
            scan_x_q     <= '0;
            scan_y_q     <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            spawn_fail_q <= 1'b0;
            lfsr_step_q  <= 1'b0;
            occ_req_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tries_q      <= tries_d;
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            spawn_fail_q <= spawn_fail_d;
            lfsr_step_q  <= (state_d == STEP);
            occ_req_q    <= (state_d == PROBE);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign lfsr_step  = lfsr_step_q;
    assign occ_req    = occ_req_q;
    assign occ_x      = cand_x_q;
    assign occ_y      = cand_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign busy       = busy_q;
    assign spawn_fail = spawn_fail_q;

endmodule
